// File: rtl/ajuste_pkg.sv
// ---------------------------------------------------------------------------
// ajuste_pkg
// Shared definitions for the time-setting controller: field-select
// encodings, per-field maximum values and the wrap-around step helper.
// ---------------------------------------------------------------------------
package ajuste_pkg;

    // Encoding 2'd3 is unused; the field FSM steers it back to HORAS.
    typedef enum logic [1:0] {
        HORAS    = 2'd0,
        MINUTOS  = 2'd1,
        SEGUNDOS = 2'd2
    } campo_t;

    localparam logic [4:0] MAX_HORAS   = 5'd23;
    localparam logic [5:0] MAX_MIN_SEG = 6'd59;

    // One wrap-around step of a field whose range is 0..max.
    // sube = 1 increments, sube = 0 decrements.
    function automatic logic [5:0] paso_campo(input logic [5:0] valor,
                                              input logic [5:0] max,
                                              input logic       sube);
        logic [5:0] res;
        if (sube) begin
            res = (valor == max) ? 6'd0 : valor + 6'd1;
        end else begin
            res = (valor == 6'd0) ? max : valor - 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/repetidor_pulso.sv
// ---------------------------------------------------------------------------
// repetidor_pulso
// Rising-edge detector plus hold counter. Emits a one-cycle step on the
// rising edge of i_nivel and, while the level stays high, an auto-repeat
// step REPEAT_DELAY cycles after the edge and then every REPEAT_PERIOD
// cycles. With REPEAT_EN = 0 only the edge step is produced.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low
//   i_nivel    in   debounced button level
//   i_limpiar  in   clears the repeat state (edge history keeps tracking)
//   o_paso     out  step pulse (edge or repeat tick); caller arbitrates
// ---------------------------------------------------------------------------
module repetidor_pulso #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_nivel,
    input  logic i_limpiar,
    output logic o_paso
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);

    logic          r_hist;
    logic          r_armado;   // low until the first sample after reset
    logic          r_activo;   // button held since a qualified rising edge
    logic          r_repite;   // initial delay done, now in period phase
    logic [CW-1:0] r_cnt;      // cycles since the last step

    logic w_flanco;
    logic w_tick;

    // r_armado blocks a level that is already high when reset releases.
    assign w_flanco = i_nivel & ~r_hist & r_armado;
    assign w_tick   = REPEAT_EN & r_activo & i_nivel &
                      (r_repite ? (r_cnt == PERIOD_C) : (r_cnt == DELAY_C));
    assign o_paso   = w_flanco | w_tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist   <= 1'b0;
            r_armado <= 1'b0;
            r_activo <= 1'b0;
            r_repite <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_hist   <= i_nivel;
            r_armado <= 1'b1;
            if (!i_nivel || i_limpiar) begin
                r_activo <= 1'b0;
                r_repite <= 1'b0;
                r_cnt    <= '0;
            end else if (w_flanco) begin
                // Counter value j at edge k+j means j held cycles since the edge.
                r_activo <= 1'b1;
                r_repite <= 1'b0;
                r_cnt    <= CW'(1);
            end else if (w_tick) begin
                r_repite <= 1'b1;
                r_cnt    <= CW'(1);
            end else if (r_activo && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);   // saturates, never wraps
            end
        end
    end

endmodule

// File: rtl/ajuste_hora.sv
// ---------------------------------------------------------------------------
// ajuste_hora
// Time-setting controller. Converts debounced au/dis/sel levels into
// single steps (with auto-repeat on au/dis), walks a field pointer over
// hours/minutes/seconds and increments or decrements the selected field
// with wrap-around.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low
//   au         in   debounced increment level
//   dis        in   debounced decrement level
//   sel        in   debounced field-select level
//   habilitar  in   low = ignore all button activity
//   horas      out  hours 0..23
//   minutos    out  minutes 0..59
//   segundos   out  seconds 0..59
//   campo      out  selected field (0 HORAS, 1 MINUTOS, 2 SEGUNDOS)
//   cambio     out  one-cycle pulse, the cycle after a field changed
// ---------------------------------------------------------------------------
module ajuste_hora
    import ajuste_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       au,
    input  logic       dis,
    input  logic       sel,
    input  logic       habilitar,
    output logic [4:0] horas,
    output logic [5:0] minutos,
    output logic [5:0] segundos,
    output logic [1:0] campo,
    output logic       cambio
);

    logic       w_paso_au;
    logic       w_paso_dis;
    logic       w_paso_sel;
    logic       w_ambos;
    logic       w_sel;
    logic       w_limpiar;
    logic       w_inc;
    logic       w_dec;
    logic       w_campo_valido;
    logic       w_escribe;

    campo_t     r_campo;
    logic [4:0] r_horas;
    logic [5:0] r_minutos;
    logic [5:0] r_segundos;
    logic       r_escrito;   // a field was written at the previous edge
    logic       r_cambio;

    repetidor_pulso #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .REPEAT_EN     (1'b1)
    ) u_rep_au (
        .clk       (clk),
        .reset     (reset),
        .i_nivel   (au),
        .i_limpiar (w_limpiar),
        .o_paso    (w_paso_au)
    );

    repetidor_pulso #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .REPEAT_EN     (1'b1)
    ) u_rep_dis (
        .clk       (clk),
        .reset     (reset),
        .i_nivel   (dis),
        .i_limpiar (w_limpiar),
        .o_paso    (w_paso_dis)
    );

    // Field select only needs the edge detector.
    repetidor_pulso #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .REPEAT_EN     (1'b0)
    ) u_edge_sel (
        .clk       (clk),
        .reset     (reset),
        .i_nivel   (sel),
        .i_limpiar (~habilitar),
        .o_paso    (w_paso_sel)
    );

    // Arbitration: both step buttons high cancels stepping; a select edge
    // wins over a coincident step. Either case, or disable, kills repeats.
    assign w_ambos        = au & dis;
    assign w_sel          = habilitar & w_paso_sel;
    assign w_limpiar      = ~habilitar | w_ambos | (w_paso_sel & (w_paso_au | w_paso_dis));
    assign w_inc          = habilitar & w_paso_au  & ~w_ambos & ~w_paso_sel;
    assign w_dec          = habilitar & w_paso_dis & ~w_ambos & ~w_paso_sel;
    assign w_campo_valido = r_campo inside {HORAS, MINUTOS, SEGUNDOS};
    assign w_escribe      = (w_inc | w_dec) & w_campo_valido;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_campo    <= HORAS;
            r_horas    <= '0;
            r_minutos  <= '0;
            r_segundos <= '0;
            r_escrito  <= 1'b0;
            r_cambio   <= 1'b0;
        end else begin
            if (w_sel) begin
                case (r_campo)
                    HORAS:    r_campo <= MINUTOS;
                    MINUTOS:  r_campo <= SEGUNDOS;
                    default:  r_campo <= HORAS;   // SEGUNDOS and illegal 3
                endcase
            end

            if (w_escribe) begin
                case (r_campo)
                    HORAS:    r_horas    <= 5'(paso_campo({1'b0, r_horas}, {1'b0, MAX_HORAS}, w_inc));
                    MINUTOS:  r_minutos  <= paso_campo(r_minutos, MAX_MIN_SEG, w_inc);
                    default:  r_segundos <= paso_campo(r_segundos, MAX_MIN_SEG, w_inc);
                endcase
            end

            // Every write changes the value (ranges are wider than one), so
            // the write strobe delayed by one more cycle gives cambio.
            r_escrito <= w_escribe;
            r_cambio  <= r_escrito;
        end
    end

    assign horas    = r_horas;
    assign minutos  = r_minutos;
    assign segundos = r_segundos;
    assign campo    = r_campo;
    assign cambio   = r_cambio;

endmodule

// File: tb/tb_ajuste_hora.sv
// ---------------------------------------------------------------------------
// tb_ajuste_hora
// Directed bench for ajuste_hora with REPEAT_DELAY = 8, REPEAT_PERIOD = 4.
// Each vector is one clock edge: inputs are applied between edges and the
// outputs are compared 1 ns after the edge that sampled them.
// ---------------------------------------------------------------------------
module tb_ajuste_hora;

    logic       clk = 1'b0;
    logic       reset;
    logic       au, dis, sel, habilitar;
    logic [4:0] horas;
    logic [5:0] minutos;
    logic [5:0] segundos;
    logic [1:0] campo;
    logic       cambio;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic au;
        logic dis;
        logic sel;
        logic hab;
        int   h;
        int   m;
        int   s;
        int   c;
        int   cb;
    } vec_t;

    vec_t tabla1[17];
    vec_t tabla2[23];

    ajuste_hora #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .au        (au),
        .dis       (dis),
        .sel       (sel),
        .habilitar (habilitar),
        .horas     (horas),
        .minutos   (minutos),
        .segundos  (segundos),
        .campo     (campo),
        .cambio    (cambio)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic a, input logic d, input logic s_, input logic hb,
                                input int h, input int m, input int s, input int c, input int cb);
        vec_t v;
        v.au = a; v.dis = d; v.sel = s_; v.hab = hb;
        v.h = h; v.m = m; v.s = s; v.c = c; v.cb = cb;
        return v;
    endfunction

    task automatic chk(input string nombre, input logic [31:0] got, input int exp_v);
        n_tests++;
        if (got !== 32'(exp_v)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nombre, got, exp_v);
        end
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int h, input int m, input int s,
                           input int c, input int cb);
        chk({tag, ".horas"},    32'(horas),    h);
        chk({tag, ".minutos"},  32'(minutos),  m);
        chk({tag, ".segundos"}, 32'(segundos), s);
        chk({tag, ".campo"},    32'(campo),    c);
        chk({tag, ".cambio"},   32'(cambio),   cb);
        $display("[TB] %s: au=%0b dis=%0b sel=%0b hab=%0b -> h=%0d m=%0d s=%0d campo=%0d cambio=%0b",
                 tag, au, dis, sel, habilitar, horas, minutos, segundos, campo, cambio);
    endtask

    task automatic aplicar(input string tag, input vec_t v);
        au = v.au; dis = v.dis; sel = v.sel; habilitar = v.hab;
        edge_clk();
        chk_all(tag, v.h, v.m, v.s, v.c, v.cb);
    endtask

    initial begin
        // Starts after reset-release with au held; au/dis/sel edges, wraps.
        tabla1[0]  = mk(0,0,0,1,  0, 0, 0,0,0);  // release au
        tabla1[1]  = mk(0,1,0,1, 23, 0, 0,0,0);  // dis: 0 -> 23
        tabla1[2]  = mk(0,0,0,1, 23, 0, 0,0,1);  // cambio one cycle later
        tabla1[3]  = mk(0,0,0,1, 23, 0, 0,0,0);
        tabla1[4]  = mk(1,0,0,1,  0, 0, 0,0,0);  // au: 23 -> 0
        tabla1[5]  = mk(1,0,0,1,  0, 0, 0,0,1);  // held, no extra step
        tabla1[6]  = mk(0,0,0,1,  0, 0, 0,0,0);
        tabla1[7]  = mk(0,0,1,1,  0, 0, 0,1,0);  // sel -> MINUTOS
        tabla1[8]  = mk(0,0,0,1,  0, 0, 0,1,0);
        tabla1[9]  = mk(0,0,1,1,  0, 0, 0,2,0);  // sel -> SEGUNDOS
        tabla1[10] = mk(0,0,0,1,  0, 0, 0,2,0);
        tabla1[11] = mk(0,1,0,1,  0, 0,59,2,0);  // dis: 0 -> 59
        tabla1[12] = mk(0,0,0,1,  0, 0,59,2,1);
        tabla1[13] = mk(0,0,1,1,  0, 0,59,0,0);  // sel wraps to HORAS
        tabla1[14] = mk(0,0,0,1,  0, 0,59,0,0);
        tabla1[15] = mk(0,0,1,1,  0, 0,59,1,0);  // -> MINUTOS
        tabla1[16] = mk(0,0,0,1,  0, 0,59,1,0);

        // Starts at h=0 m=14 s=59 campo=MINUTOS: collisions and disable.
        tabla2[0]  = mk(1,1,0,1,  0,14,59,1,0);  // au+dis together: no step
        tabla2[1]  = mk(1,1,0,1,  0,14,59,1,0);
        tabla2[2]  = mk(0,0,0,1,  0,14,59,1,0);
        tabla2[3]  = mk(1,0,1,1,  0,14,59,2,0);  // sel edge + au edge
        tabla2[4]  = mk(0,0,0,1,  0,14,59,2,0);
        tabla2[5]  = mk(0,0,0,0,  0,14,59,2,0);  // disabled
        tabla2[6]  = mk(1,1,1,0,  0,14,59,2,0);
        tabla2[7]  = mk(0,0,0,0,  0,14,59,2,0);
        tabla2[8]  = mk(1,0,0,0,  0,14,59,2,0);  // au rises while disabled
        for (int i = 9; i <= 18; i++)
            tabla2[i] = mk(1,0,0,1, 0,14,59,2,0); // re-enabled, au still high
        tabla2[19] = mk(0,0,0,1,  0,14,59,2,0);
        tabla2[20] = mk(0,1,0,1,  0,14,58,2,0);  // fresh dis edge works
        tabla2[21] = mk(0,0,0,1,  0,14,58,2,1);
        tabla2[22] = mk(0,0,0,1,  0,14,58,2,0);

        // Reset with au held.
        reset = 1'b0; au = 1'b1; dis = 1'b0; sel = 1'b0; habilitar = 1'b1;
        edge_clk();
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            edge_clk();
            chk_all($sformatf("post_reset_hold%0d", i), 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < 17; i++)
            aplicar($sformatf("t1_%0d", i), tabla1[i]);

        // Bring minutos to 10 with single presses.
        for (int i = 0; i < 10; i++) begin
            au = 1'b1; edge_clk();
            au = 1'b0; edge_clk();
        end
        edge_clk();
        edge_clk();
        chk_all("setup_min10", 0, 10, 59, 1, 0);

        // Hold au 20 cycles: steps at relative edges 0, 8, 12, 16.
        for (int j = 0; j < 20; j++) begin
            int exp_m;
            exp_m = 11 + ((j >= 8) ? 1 : 0) + ((j >= 12) ? 1 : 0) + ((j >= 16) ? 1 : 0);
            au = 1'b1;
            edge_clk();
            chk($sformatf("hold%0d.minutos", j), 32'(minutos), exp_m);
            $display("[TB] hold%0d: minutos=%0d", j, minutos);
        end
        au = 1'b0;
        edge_clk();
        edge_clk();
        chk_all("hold_release", 0, 14, 59, 1, 0);

        for (int i = 0; i < 23; i++)
            aplicar($sformatf("t2_%0d", i), tabla2[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
